// File: rtl/sw_mem_pkg.sv
// rtl/sw_mem_pkg.sv - shared widths, request/beat types and FSM states for dram_read_responder
package sw_mem_pkg;

  localparam int DATA_W   = 256;
  localparam int ID_W     = 6;
  localparam int LEN_W    = 8;
  localparam int ADDR_W   = 32;
  localparam int BYTE_OFS = 5;
  localparam int WORD_W   = ADDR_W - BYTE_OFS;

  // Word keeps the full untruncated index so range checks can see the upper bits
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [WORD_W-1:0] word;
    logic [LEN_W-1:0]  len;
  } rd_req_t;

  typedef struct packed {
    logic              last;
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } rd_beat_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } rd_state_e;

endpackage

// File: rtl/rd_req_fifo.sv
// rtl/rd_req_fifo.sv - synchronous FIFO of burst read requests with full/empty flags
module rd_req_fifo
  import sw_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    i_push,
  input  rd_req_t i_data,
  input  logic    i_pop,
  output rd_req_t o_head,
  output logic    o_full,
  output logic    o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT = DEPTH[PW:0];
  localparam logic [PW:0]   CNT_ONE  = 1;
  localparam logic [PW-1:0] PTR_ONE  = 1;

  rd_req_t       r_slot [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_head    = r_slot[r_rd_ptr];

  // Request storage; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_slot[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dram_read_responder.sv
// rtl/dram_read_responder.sv - on-chip burst read responder with preload port; option RD_BOUNDS_CHECK_EN
module dram_read_responder
  import sw_mem_pkg::*;
#(
  parameter int MEM_WORDS = 4096,
  parameter int REQ_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ID_W-1:0]              rd_id_in,
  input  logic [ADDR_W-1:0]            rd_addr_in,
  input  logic [LEN_W-1:0]             rd_len_in,
  input  logic                         rd_info_valid_in,
  output logic                         rd_info_rdy_out,
  output logic [DATA_W-1:0]            rd_data_out,
  output logic [ID_W-1:0]              rd_data_id_out,
  output logic                         rd_data_last_out,
  output logic                         rd_data_valid_out,
  input  logic                         rd_data_rdy_in,
  input  logic                         wr_en_in,
  input  logic [$clog2(MEM_WORDS)-1:0] wr_addr_in,
  input  logic [DATA_W-1:0]            wr_data_in
`ifdef RD_BOUNDS_CHECK_EN
  ,
  output logic                         rd_err_out
`endif
);

  localparam int MW = $clog2(MEM_WORDS);
  localparam logic [MW-1:0]    PTR_ONE = 1;
  localparam logic [LEN_W-1:0] LEN_ONE = 1;

  rd_req_t     w_req_in;
  rd_req_t     w_head;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;

  rd_state_e   r_state;
  rd_state_e   w_state_nxt;
  logic        w_issue;
  logic        w_last_read;
  logic        w_space_ok;
  logic        w_zero_beat;

  logic [MW-1:0]    r_ptr;
  logic [LEN_W-1:0] r_remain;
  logic [ID_W-1:0]  r_id;

  logic [DATA_W-1:0] r_mem [MEM_WORDS];
  logic              r_rd_vld;
  logic [DATA_W-1:0] r_rd_data;
  logic [ID_W-1:0]   r_rd_id;
  logic              r_rd_last;
  rd_beat_t          w_rd_beat;

  logic [1:0]  r_occ;
  rd_beat_t    r_b0;
  rd_beat_t    r_b1;
  logic        w_out_pop;
  logic [2:0]  w_level;
  logic        w_unused_bits;

  assign w_req_in        = '{id: rd_id_in, word: rd_addr_in[ADDR_W-1:BYTE_OFS], len: rd_len_in};
  assign rd_info_rdy_out = !w_full;
  assign w_push          = rd_info_valid_in && !w_full;
  assign w_unused_bits   = &{1'b0, rd_addr_in[BYTE_OFS-1:0], w_head.word[WORD_W-1:MW]};

  rd_req_fifo #(.DEPTH(REQ_DEPTH)) u_req_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_req_in),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

`ifdef RD_BOUNDS_CHECK_EN
  localparam logic [WORD_W:0] LIMIT = MEM_WORDS[WORD_W:0];
  logic [WORD_W:0] w_head_end;
  logic            w_head_bad;
  logic            r_bad;
  logic            r_err;

  assign w_head_end  = {1'b0, w_head.word} + {{(WORD_W + 1 - LEN_W){1'b0}}, w_head.len};
  assign w_head_bad  = ({1'b0, w_head.word} >= LIMIT) || (w_head_end >= LIMIT);
  assign w_zero_beat = r_bad;
  assign rd_err_out  = r_err;

  // Out-of-range flag for the active burst and the sticky error seen by the host
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bad <= 1'b0;
      r_err <= 1'b0;
    end else if (w_pop) begin
      r_bad <= w_head_bad;
      if (w_head_bad) r_err <= 1'b1;
    end
  end
`else
  assign w_zero_beat = 1'b0;
`endif

  // Beats held by the skid buffer plus the one in the BRAM stage, minus this cycle's drain
  assign w_out_pop  = (r_occ != 2'd0) && rd_data_rdy_in;
  assign w_level    = {1'b0, r_occ} + {2'b00, r_rd_vld} - {2'b00, w_out_pop};
  assign w_space_ok = (w_level < 3'd2);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state: a finishing burst chains into the next queued one without a bubble
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (!w_empty) w_state_nxt = ST_BURST;
      ST_BURST: if (w_last_read && w_empty) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: memory read issue and request pop
  always_comb begin
    w_issue     = 1'b0;
    w_last_read = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_pop = !w_empty;
      end
      ST_BURST: begin
        w_issue     = w_space_ok;
        w_last_read = w_space_ok && (r_remain == '0);
        w_pop       = w_last_read && !w_empty;
      end
      default: begin
        w_pop = 1'b0;
      end
    endcase
  end

  // Burst context: load on pop, advance (wrapping modulo MEM_WORDS) on each read
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr    <= '0;
      r_remain <= '0;
      r_id     <= '0;
    end else if (w_pop) begin
      r_ptr    <= w_head.word[MW-1:0];
      r_remain <= w_head.len;
      r_id     <= w_head.id;
    end else if (w_issue) begin
      r_ptr    <= r_ptr + PTR_ONE;
      r_remain <= r_remain - LEN_ONE;
    end
  end

  // Memory array with preload write and registered read; read-first on address collision
  always_ff @(posedge clk) begin
    if (wr_en_in) begin
      r_mem[wr_addr_in] <= wr_data_in;
    end
    if (w_issue) begin
      r_rd_data <= w_zero_beat ? '0 : r_mem[r_ptr];
    end
  end

  // Sideband travelling alongside the BRAM read; reset discards the in-flight beat
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_vld  <= 1'b0;
      r_rd_id   <= '0;
      r_rd_last <= 1'b0;
    end else begin
      r_rd_vld <= w_issue;
      if (w_issue) begin
        r_rd_id   <= r_id;
        r_rd_last <= (r_remain == '0);
      end
    end
  end

  assign w_rd_beat = '{last: r_rd_last, id: r_rd_id, data: r_rd_data};

  // Two-entry skid buffer; head entry only changes when empty or accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ <= 2'd0;
      r_b0  <= '0;
      r_b1  <= '0;
    end else begin
      case (r_occ)
        2'd0: begin
          if (r_rd_vld) begin
            r_b0  <= w_rd_beat;
            r_occ <= 2'd1;
          end
        end
        2'd1: begin
          if (r_rd_vld && w_out_pop) begin
            r_b0 <= w_rd_beat;
          end else if (r_rd_vld) begin
            r_b1  <= w_rd_beat;
            r_occ <= 2'd2;
          end else if (w_out_pop) begin
            r_occ <= 2'd0;
          end
        end
        default: begin
          if (w_out_pop) begin
            r_b0 <= r_b1;
            if (r_rd_vld) r_b1 <= w_rd_beat;
            else          r_occ <= 2'd1;
          end
        end
      endcase
    end
  end

  assign rd_data_valid_out = (r_occ != 2'd0);
  assign rd_data_out       = r_b0.data;
  assign rd_data_id_out    = r_b0.id;
  assign rd_data_last_out  = r_b0.last;

endmodule

// File: tb/tb_dram_read_responder.sv
// tb/tb_dram_read_responder.sv - scoreboard bench for dram_read_responder
module tb_dram_read_responder;

  localparam int MEM_WORDS = 4096;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   rd_id_in;
  logic [31:0]  rd_addr_in;
  logic [7:0]   rd_len_in;
  logic         rd_info_valid_in;
  logic         rd_info_rdy_out;
  logic [255:0] rd_data_out;
  logic [5:0]   rd_data_id_out;
  logic         rd_data_last_out;
  logic         rd_data_valid_out;
  logic         rd_data_rdy_in;
  logic         wr_en_in;
  logic [11:0]  wr_addr_in;
  logic [255:0] wr_data_in;
`ifdef RD_BOUNDS_CHECK_EN
  logic         rd_err_out;
`endif

  always #5 clk = ~clk;

  dram_read_responder #(.MEM_WORDS(MEM_WORDS), .REQ_DEPTH(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .rd_id_in          (rd_id_in),
    .rd_addr_in        (rd_addr_in),
    .rd_len_in         (rd_len_in),
    .rd_info_valid_in  (rd_info_valid_in),
    .rd_info_rdy_out   (rd_info_rdy_out),
    .rd_data_out       (rd_data_out),
    .rd_data_id_out    (rd_data_id_out),
    .rd_data_last_out  (rd_data_last_out),
    .rd_data_valid_out (rd_data_valid_out),
    .rd_data_rdy_in    (rd_data_rdy_in),
    .wr_en_in          (wr_en_in),
    .wr_addr_in        (wr_addr_in),
    .wr_data_in        (wr_data_in)
`ifdef RD_BOUNDS_CHECK_EN
    ,
    .rd_err_out        (rd_err_out)
`endif
  );

  typedef struct packed {
    logic [255:0] data;
    logic [5:0]   id;
    logic         last;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  logic [255:0] model [MEM_WORDS];
  int           checks = 0;
  int           errors = 0;

  logic         hold_v = 1'b0;
  logic [255:0] hold_d;
  logic [5:0]   hold_id;
  logic         hold_last;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: compare every accepted beat against the queue, and stalled beats for stability
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("stall_valid", rd_data_valid_out, 1'b1);
        chk("stall_data", rd_data_out, hold_d);
        chk("stall_id", rd_data_id_out, hold_id);
        chk("stall_last", rd_data_last_out, hold_last);
      end
      if (rd_data_valid_out && rd_data_rdy_in) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got id %0d data %0h expected no beat", rd_data_id_out, rd_data_out);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat_data", rd_data_out, mon_e.data);
          chk("beat_id", rd_data_id_out, mon_e.id);
          chk("beat_last", rd_data_last_out, mon_e.last);
        end
      end
      hold_v    = rd_data_valid_out && !rd_data_rdy_in;
      hold_d    = rd_data_out;
      hold_id   = rd_data_id_out;
      hold_last = rd_data_last_out;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int idx, input logic [255:0] data);
    wr_en_in   = 1'b1;
    wr_addr_in = idx[11:0];
    wr_data_in = data;
    tick();
    wr_en_in   = 1'b0;
    model[idx] = data;
  endtask

  task automatic send_req(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len);
    int          n;
    logic [11:0] wi;
    logic [27:0] s;
    logic [27:0] e;
    logic        bad;
    rd_id_in         = id;
    rd_addr_in       = addr;
    rd_len_in        = len;
    rd_info_valid_in = 1'b1;
    n = 0;
    while (!rd_info_rdy_out && n < 200) begin
      tick();
      n++;
    end
    if (!rd_info_rdy_out) begin
      checks++;
      errors++;
      $display("FAIL req_accept_timeout: id %0d not accepted after %0d cycles", id, n);
      rd_info_valid_in = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    rd_info_valid_in = 1'b0;
    s   = addr[31:5];
    e   = s + {20'd0, len};
    bad = 1'b0;
`ifdef RD_BOUNDS_CHECK_EN
    bad = (s >= 28'd4096) || (e >= 28'd4096);
`endif
    for (int b = 0; b <= int'(len); b++) begin
      wi = addr[16:5] + b[11:0];
      exp_q.push_back('{data: bad ? 256'd0 : model[wi], id: id, last: (b == int'(len))});
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rd_data_valid_out) && n < 500) begin
      tick();
      n++;
    end
    chk(name, 256'(exp_q.size()), 256'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst              = 1'b1;
    rd_id_in         = '0;
    rd_addr_in       = '0;
    rd_len_in        = '0;
    rd_info_valid_in = 1'b0;
    rd_data_rdy_in   = 1'b0;
    wr_en_in         = 1'b0;
    wr_addr_in       = '0;
    wr_data_in       = '0;
    tick(); tick(); tick();

    chk("rst_info_rdy", rd_info_rdy_out, 1'b1);
    chk("rst_valid", rd_data_valid_out, 1'b0);
    chk("rst_last", rd_data_last_out, 1'b0);
    chk("rst_id", rd_data_id_out, 6'd0);
    chk("rst_data", rd_data_out, 256'd0);
`ifdef RD_BOUNDS_CHECK_EN
    chk("rst_err", rd_err_out, 1'b0);
`endif
    rst = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) preload(i, 256'(i));
    preload(MEM_WORDS - 1, 256'hDEAD_BEEF_0FFF);
    rd_data_rdy_in = 1'b1;

    // Single burst: first beat three cycles after accept, then one beat per cycle
    send_req(6'd5, 32'h0, 8'd3);
    chk("t1_lat0", rd_data_valid_out, 1'b0);
    tick();
    chk("t1_lat1", rd_data_valid_out, 1'b0);
    tick();
    chk("t1_lat2", rd_data_valid_out, 1'b0);
    tick();
    chk("t1_lat3", rd_data_valid_out, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t1_stream", rd_data_valid_out, 1'b1);
    end
    wait_drain("t1_drain");

    // Back-to-back bursts: words 2, 8, 9 with no gap
    send_req(6'd1, 32'h40, 8'd0);
    send_req(6'd2, 32'h100, 8'd1);
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("t2_no_gap", rd_data_valid_out, 1'b1);
      tick();
    end
    wait_drain("t2_drain");

    // Eight beats under a 1010 consumer pattern
    send_req(6'd3, 32'h0, 8'd7);
    for (int k = 0; k < 60; k++) begin
      rd_data_rdy_in = (k % 2 == 0);
      tick();
    end
    rd_data_rdy_in = 1'b1;
    wait_drain("t3_drain");

    // Backpressure: engine holds a stalled burst, four more fill the FIFO, the next waits
    rd_data_rdy_in = 1'b0;
    send_req(6'd10, 32'h0, 8'd3);
    tick();
    tick();
    for (int i = 0; i < 4; i++) send_req(6'(11 + i), 32'((4 + i) * 32), 8'd0);
    chk("t4_full_after_4th", rd_info_rdy_out, 1'b0);
    rd_id_in         = 6'd15;
    rd_addr_in       = 32'(9 * 32);
    rd_len_in        = 8'd0;
    rd_info_valid_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t4_held", rd_info_rdy_out, 1'b0);
    end
    rd_data_rdy_in = 1'b1;
    send_req(6'd15, 32'(9 * 32), 8'd0);
    wait_drain("t4_drain");

    // Top-of-memory burst: wraps to word 0, or zero beats with the range check
    preload(0, 256'hF00D);
    send_req(6'd4, 32'((MEM_WORDS - 1) * 32), 8'd1);
    wait_drain("t5_drain");
`ifdef RD_BOUNDS_CHECK_EN
    chk("t5_err", rd_err_out, 1'b1);
`endif

    // Reset while beat 2 of an eight-beat burst is on the output
    send_req(6'd7, 32'h0, 8'd7);
    tick(); tick(); tick();
    tick(); tick();
    rst            = 1'b1;
    rd_data_rdy_in = 1'b0;
    tick();
    chk("t6_valid_after_rst", rd_data_valid_out, 1'b0);
    chk("t6_rdy_after_rst", rd_info_rdy_out, 1'b1);
`ifdef RD_BOUNDS_CHECK_EN
    chk("t6_err_after_rst", rd_err_out, 1'b0);
`endif
    exp_q.delete();
    rst            = 1'b0;
    rd_data_rdy_in = 1'b1;
    tick();
    send_req(6'd9, 32'(3 * 32), 8'd1);
    wait_drain("t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
